// File: rtl/hex_text_scroller.sv
// Scrolls a NUL-terminated text snapshot right-to-left across N_DIGITS 7-seg digits; optional pause input under `SCROLL_PAUSE_EN.
// Latency: SCAN takes min(len+1,N_CHARS) cycles; hex_out follows pos one cycle later.
// No backpressure: load is always honoured, pause (when built) freezes scrolling.
module hex_text_scroller #(
  parameter int N_CHARS     = 100,
  parameter int N_DIGITS    = 6,
  parameter int STEP_CYCLES = 25_000_000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
`ifdef SCROLL_PAUSE_EN
  input  logic                  pause,
`endif
  input  logic [8*N_CHARS-1:0]  buf_in,
  output logic [7*N_DIGITS-1:0] hex_out,
  output logic                  busy,
  output logic                  wrap
);

  localparam int PW = (STEP_CYCLES > 2) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(STEP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SCAN, SCROLL} state_t;

  state_t                state, state_nxt;
  logic [7:0]            shadow [N_CHARS];
  logic [6:0]            idx, len, pos;
  logic [PW-1:0]         presc;
  logic [6:0]            period;
  logic [7:0]            byte_cur;
  logic                  scan_nul, scan_last, hold;
  logic [7:0]            win_sum [N_DIGITS];
  logic [7:0]            win_ch  [N_DIGITS];
  logic [7*N_DIGITS-1:0] win_glyphs;

`ifdef SCROLL_PAUSE_EN
  assign hold = pause;
`else
  assign hold = 1'b0;
`endif

  // Active-low segments, bit 0 = a ... bit 6 = g; letters are case-folded.
  function automatic logic [6:0] glyph(input logic [7:0] c);
    logic [7:0] u;
    u = (c >= 8'h61 && c <= 8'h7A) ? (c - 8'h20) : c;
    case (u)
      "0": glyph = 7'h40;  "1": glyph = 7'h79;  "2": glyph = 7'h24;  "3": glyph = 7'h30;
      "4": glyph = 7'h19;  "5": glyph = 7'h12;  "6": glyph = 7'h02;  "7": glyph = 7'h78;
      "8": glyph = 7'h00;  "9": glyph = 7'h10;  "-": glyph = 7'h3F;
      "A": glyph = 7'h08;  "B": glyph = 7'h03;  "C": glyph = 7'h46;  "D": glyph = 7'h21;
      "E": glyph = 7'h06;  "F": glyph = 7'h0E;  "G": glyph = 7'h42;  "H": glyph = 7'h09;
      "I": glyph = 7'h79;  "J": glyph = 7'h61;  "K": glyph = 7'h0A;  "L": glyph = 7'h47;
      "M": glyph = 7'h6A;  "N": glyph = 7'h2B;  "O": glyph = 7'h40;  "P": glyph = 7'h0C;
      "Q": glyph = 7'h18;  "R": glyph = 7'h2F;  "S": glyph = 7'h12;  "T": glyph = 7'h07;
      "U": glyph = 7'h41;  "V": glyph = 7'h63;  "W": glyph = 7'h55;  "X": glyph = 7'h36;
      "Y": glyph = 7'h11;  "Z": glyph = 7'h24;
      default: glyph = 7'h7F;
    endcase
  endfunction

  assign period   = len + 7'(N_DIGITS);
  assign byte_cur = shadow[idx];
  assign scan_nul  = (byte_cur == 8'h00);
  assign scan_last = (idx == 7'(N_CHARS - 1));
  assign busy      = (state != IDLE);

  // Stream is text then N_DIGITS blanks; pos+j < 2P so one subtract wraps it.
  always_comb begin
    win_glyphs = '1;
    for (int j = 0; j < N_DIGITS; j++) begin
      win_sum[j] = {1'b0, pos} + 8'(j);
      if (win_sum[j] >= {1'b0, period}) win_sum[j] = win_sum[j] - {1'b0, period};
      win_ch[j] = (win_sum[j] < {1'b0, len}) ? shadow[win_sum[j][6:0]] : 8'h20;
      win_glyphs[7*(N_DIGITS-1-j) +: 7] = glyph(win_ch[j]);
    end
  end

  always_comb begin
    state_nxt = state;
    if (load) begin
      state_nxt = SCAN;
    end else begin
      case (state)
        SCAN: begin
          if (scan_nul)       state_nxt = (idx == 7'd0) ? IDLE : SCROLL;
          else if (scan_last) state_nxt = SCROLL;
        end
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CHARS; i++) shadow[i] <= 8'h00;
      idx     <= '0;
      len     <= '0;
      pos     <= '0;
      presc   <= '0;
      hex_out <= '1;
      wrap    <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (load) begin
        for (int i = 0; i < N_CHARS; i++) shadow[i] <= buf_in[8*i +: 8];
        idx   <= '0;
        pos   <= '0;
        presc <= '0;
      end else begin
        case (state)
          SCAN: begin
            idx <= idx + 7'd1;
            if (scan_nul) begin
              len <= idx;
              if (idx == 7'd0) hex_out <= '1;
            end else if (scan_last) begin
              len <= 7'(N_CHARS);
            end
          end
          SCROLL: begin
            if (!hold) begin
              hex_out <= win_glyphs;
              if (presc == PRESC_LAST) begin
                presc <= '0;
                if (pos == period - 7'd1) begin
                  pos  <= '0;
                  wrap <= 1'b1;
                end else begin
                  pos <= pos + 7'd1;
                end
              end else begin
                presc <= presc + 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hex_text_scroller.sv
// Directed bench for hex_text_scroller with STEP_CYCLES=4; pause checks built only under SCROLL_PAUSE_EN.
module tb_hex_text_scroller;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         load = 1'b0;
  logic [799:0] buf_in = '0;
  logic [41:0]  hex_out;
  logic         busy;
  logic         wrap;
`ifdef SCROLL_PAUSE_EN
  logic         pause = 1'b0;
`endif

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int first_w, second_w;

  localparam logic [41:0] BLANK = {6{7'h7F}};
  localparam logic [41:0] ALL_A = {6{7'h08}};
  localparam logic [41:0] W0 = {7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12};
  localparam logic [41:0] W1 = {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02};
  localparam logic [41:0] W6 = {7'h02, 7'h78, 7'h00, 7'h10, 7'h7F, 7'h7F};
  localparam logic [41:0] W7 = {7'h78, 7'h00, 7'h10, 7'h7F, 7'h7F, 7'h7F};
`ifdef SCROLL_PAUSE_EN
  localparam logic [41:0] W2 = {7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78};
`endif

  hex_text_scroller #(.N_CHARS(100), .N_DIGITS(6), .STEP_CYCLES(4)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .load(load),
`ifdef SCROLL_PAUSE_EN
    .pause(pause),
`endif
    .buf_in(buf_in),
    .hex_out(hex_out),
    .busy(busy),
    .wrap(wrap)
  );

  always #5 clk = ~clk;

  function automatic logic [799:0] mkbuf(input string s);
    logic [799:0] b;
    b = '0;
    for (int i = 0; i < s.len(); i++) b[8*i +: 8] = s[i];
    return b;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_to(input int n);
    while (cyc < n) tick();
  endtask

  task automatic do_load(input logic [799:0] b);
    load   = 1'b1;
    buf_in = b;
    tick();
    load = 1'b0;
    cyc  = 0;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic find_wraps(input int limit);
    first_w  = -1;
    second_w = -1;
    while (cyc < limit) begin
      tick();
      if (wrap === 1'b1) begin
        if (first_w < 0)       first_w = cyc;
        else if (second_w < 0) second_w = cyc;
      end
    end
  endtask

  logic [799:0] all_a;

  initial begin
    all_a = '0;
    for (int i = 0; i < 100; i++) all_a[8*i +: 8] = 8'h41;

    // Reset state
    #12;
    check("reset_hex", hex_out, BLANK);
    check("reset_busy", busy, 1'b0);
    check("reset_wrap", wrap, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // HELLO: 6 scan cycles, period 11, wrap every 44 cycles
    do_load(mkbuf("HELLO"));
    check("hello_busy_scan", busy, 1'b1);
    wait_to(6);
    check("hello_hex_held_scan", hex_out, BLANK);
    wait_to(7);
    check("hello_left_H", hex_out[41:35], 7'h09);
    check("hello_right_blank", hex_out[6:0], 7'h7F);
    wait_to(10);
    check("hello_left_H_hold", hex_out[41:35], 7'h09);
    wait_to(11);
    check("hello_left_E", hex_out[41:35], 7'h06);
    find_wraps(100);
    check("hello_wrap1_cycle", first_w, 50);
    check("hello_wrap2_cycle", second_w, 94);

    // Digits: windows by position
    do_load(mkbuf("0123456789"));
    wait_to(11);
    check("dig_busy", busy, 1'b1);
    wait_to(12);
    check("dig_win0", hex_out, W0);
    wait_to(15);
    check("dig_win0_hold", hex_out, W0);
    wait_to(16);
    check("dig_win1", hex_out, W1);
    wait_to(39);
    check("dig_win6", hex_out, W6);
    wait_to(40);
    check("dig_win7", hex_out, W7);

    // Full buffer, no NUL: len 100, period 106
    do_load(all_a);
    wait_to(99);
    check("full_busy_scan", busy, 1'b1);
    wait_to(101);
    check("full_win_A", hex_out, ALL_A);
    find_wraps(530);
    check("full_wrap_cycle", first_w, 524);

    // Empty text: one scan cycle back to idle, blanked
    do_load('0);
    check("empty_busy_scan", busy, 1'b1);
    wait_to(1);
    check("empty_busy_idle", busy, 1'b0);
    check("empty_hex_blank", hex_out, BLANK);
    wait_to(5);
    check("empty_stays_idle", busy, 1'b0);

    // Load coincident with the wrapping step tick
    do_load(mkbuf("HELLO"));
    wait_to(49);
    load   = 1'b1;
    buf_in = mkbuf("0123456789");
    tick();
    load = 1'b0;
    cyc  = 0;
    check("coinc_no_wrap", wrap, 1'b0);
    check("coinc_busy", busy, 1'b1);
    wait_to(1);
    check("coinc_no_wrap_late", wrap, 1'b0);
    wait_to(12);
    check("coinc_win0", hex_out, W0);
    wait_to(15);
    check("coinc_win0_hold", hex_out, W0);
    wait_to(16);
    check("coinc_win1", hex_out, W1);

`ifdef SCROLL_PAUSE_EN
    pause = 1'b1;
    wait_to(36);
    check("pause_hold", hex_out, W1);
    pause = 1'b0;
    wait_to(39);
    check("pause_resume_hold", hex_out, W1);
    wait_to(40);
    check("pause_resume_step", hex_out, W2);
`endif

    // Asynchronous reset mid-cycle while scrolling
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_hex", hex_out, BLANK);
    check("async_rst_busy", busy, 1'b0);
    check("async_rst_wrap", wrap, 1'b0);
    #10;
    rst_n = 1'b1;

    // buf_in changes without load are ignored
    buf_in = mkbuf("0123456789");
    repeat (5) tick();
    check("noload_busy", busy, 1'b0);
    check("noload_hex", hex_out, BLANK);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
